// File: rtl/fact_ctrl_unit.sv
// Factorial control FSM: sequences counter load/decrement and product
// register updates, then reports done or an out-of-range error.
module fact_ctrl_unit #(
  parameter int WIDTH = 4,
  parameter int MAX_N = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] n_in,
  input  logic             gt_one,
  output logic             ld_count,
  output logic             cnt_en,
  output logic             ld_prod,
  output logic             sel_init,
  output logic             oe,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    TEST = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t state;
  state_t nxt;
  logic   go_q;
  logic   go_rise;
  logic   n_bad;

  assign go_rise   = go & ~go_q;
  assign n_bad     = {{(32-WIDTH){1'b0}}, n_in} > 32'(MAX_N);
  assign state_dbg = state;

  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE: begin
        if (go_rise) nxt = n_bad ? ERR : LOAD;
        else         nxt = IDLE;
      end
      LOAD: nxt = TEST;
      TEST: nxt = gt_one ? MUL : DONE;
      MUL:  nxt = TEST;
      DONE: nxt = go ? DONE : IDLE;
      ERR:  nxt = go ? ERR : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      go_q     <= 1'b1;
      ld_count <= 1'b0;
      cnt_en   <= 1'b0;
      ld_prod  <= 1'b0;
      sel_init <= 1'b0;
      oe       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= nxt;
      go_q     <= go;
      ld_count <= (nxt == LOAD);
      cnt_en   <= (nxt == MUL);
      ld_prod  <= (nxt == LOAD) || (nxt == MUL);
      sel_init <= (nxt == LOAD);
      oe       <= (nxt == DONE);
      busy     <= (nxt == LOAD) || (nxt == TEST) || (nxt == MUL);
      done     <= (nxt == DONE);
      err      <= (nxt == ERR);
    end
  end

endmodule

// File: tb/tb_fact_ctrl_unit.sv
// Bench for fact_ctrl_unit with a counter/product datapath model
// and a scoreboard of expected products, latencies and pulse counts.
module tb_fact_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic       go;
  logic [3:0] n_in;
  logic       gt_one;
  logic       ld_count, cnt_en, ld_prod, sel_init;
  logic       oe, busy, done, err;
  logic [2:0] state_dbg;

  fact_ctrl_unit #(.WIDTH(4), .MAX_N(12)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .n_in(n_in),
    .gt_one(gt_one), .ld_count(ld_count), .cnt_en(cnt_en),
    .ld_prod(ld_prod), .sel_init(sel_init), .oe(oe),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // datapath model
  logic [3:0]  cnt_m  = '0;
  logic [31:0] prod_m = '0;
  assign gt_one = (cnt_m > 4'd1);
  always @(posedge clk) begin
    if (ld_count)    cnt_m <= n_in;
    else if (cnt_en) cnt_m <= cnt_m - 4'd1;
    if (ld_prod) prod_m <= sel_init ? 32'd1 : prod_m * {28'd0, cnt_m};
  end

  typedef struct {
    int          n;
    logic [31:0] prod;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sbq[$];

  int vectors = 0;
  int miscompares = 0;

  wire [10:0] outs = {ld_count, cnt_en, ld_prod, sel_init, oe,
                      busy, done, err, state_dbg};

  int   cnt_p = 0;
  int   ld_p  = 0;
  logic done_q = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (ld_count) begin cnt_p = 0; ld_p = 0; end
    if (cnt_en)  cnt_p++;
    if (ld_prod) ld_p++;
    if ((ld_count && cnt_en) || (cnt_en && state_dbg != 3'd3)) begin
      miscompares++;
      $display("FAIL cnt_en_excl: cnt_en=%b ld_count=%b state=%0d",
               cnt_en, ld_count, state_dbg);
    end
    if (done && !done_q) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL sb_empty: done rose with no pending start");
      end else begin
        e  = sbq.pop_front();
        ec = (e.n > 1) ? e.n - 1 : 0;
        if (prod_m !== e.prod || (cyc - e.t0) != e.lat ||
            cnt_p != ec || ld_p != ec + 1) begin
          miscompares++;
          $display("FAIL sb_n%0d: prod=%0d lat=%0d cnt=%0d ld=%0d, want %0d %0d %0d %0d",
                   e.n, prod_m, cyc - e.t0, cnt_p, ld_p, e.prod, e.lat, ec, ec + 1);
        end
      end
    end
    done_q = done;
  end

  task automatic start(input int n, input bit push, output int t0);
    exp_t e;
    logic [31:0] f;
    @(negedge clk);
    n_in = 4'(n);
    go = 1'b1;
    t0 = cyc;
    if (push) begin
      f = 32'd1;
      for (int i = 2; i <= n; i++) f = f * 32'(i);
      e.n = n; e.prod = f; e.t0 = cyc;
      e.lat = (n >= 1) ? 2 * n + 1 : 3;
      sbq.push_back(e);
    end
  endtask

  task automatic test_reset();
    int t0;
    int k;
    go = 1'b1; rst_n = 1'b0; n_in = 4'd2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (outs !== 11'd0) begin
        miscompares++;
        $display("FAIL reset_go_held: outs=%b want 0", outs);
      end
    end
    go = 1'b0;
    start(2, 1, t0);
    @(negedge clk);
    vectors++;
    if (state_dbg !== 3'd1 || ld_count !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_then_load: state=%0d ld_count=%b want 1 1",
               state_dbg, ld_count);
    end
    k = 0;
    while (!done && k < 40) begin @(negedge clk); k++; end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_n2_done: done=%b want 1", done);
    end
    go = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_n5();
    int t0;
    logic ex;
    start(5, 1, t0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      ex = (k % 2 == 1) && k >= 3 && k <= 9;
      vectors++;
      if (cnt_en !== ex) begin
        miscompares++;
        $display("FAIL n5_cnt_en_t%0d: cnt_en=%b want %b", k, cnt_en, ex);
      end
    end
    vectors++;
    if ({done, oe} !== 2'b11) begin
      miscompares++;
      $display("FAIL n5_done_t11: done,oe=%b want 11", {done, oe});
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({done, oe, state_dbg} !== 5'b11100) begin
      miscompares++;
      $display("FAIL n5_done_hold: done,oe,state=%b want 11100",
               {done, oe, state_dbg});
    end
    go = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || state_dbg !== 3'd0) begin
      miscompares++;
      $display("FAIL n5_done_clear: done=%b state=%0d want 0 0", done, state_dbg);
    end
  endtask

  task automatic test_small(input int n);
    int t0;
    logic [2:0] ex;
    start(n, 1, t0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      ex = (k == 1) ? 3'd1 : (k == 2) ? 3'd2 : 3'd4;
      vectors++;
      if (state_dbg !== ex || cnt_en !== 1'b0) begin
        miscompares++;
        $display("FAIL small_n%0d_t%0d: state=%0d cnt_en=%b want %0d 0",
                 n, k, state_dbg, cnt_en, ex);
      end
    end
    go = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_err();
    int t0;
    start(13, 0, t0);
    @(negedge clk);
    vectors++;
    if (state_dbg !== 3'd5 || err !== 1'b1 || busy !== 1'b0 || ld_count !== 1'b0) begin
      miscompares++;
      $display("FAIL err_t1: state=%0d err=%b busy=%b ld=%b want 5 1 0 0",
               state_dbg, err, busy, ld_count);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (state_dbg !== 3'd5 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_hold: state=%0d err=%b want 5 1", state_dbg, err);
    end
    go = 1'b0;
    @(negedge clk);
    vectors++;
    if (state_dbg !== 3'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: state=%0d err=%b want 0 0", state_dbg, err);
    end
  endtask

  task automatic test_go_toggle();
    int t0;
    start(12, 1, t0);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 4) go = 1'b0;
      if (k == 5) begin go = 1'b1; n_in = 4'd3; end
      if (k == 6) go = 1'b0;
      if (k == 24) begin
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL toggle_busy_t24: busy=%b done=%b want 1 0", busy, done);
        end
      end
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL toggle_done_t25: done=%b want 1", done);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (state_dbg !== 3'd0 || done !== 1'b0 || ld_count !== 1'b0) begin
        miscompares++;
        $display("FAIL toggle_idle_%0d: state=%0d done=%b ld=%b want 0 0 0",
                 k, state_dbg, done, ld_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    int k;
    start(6, 1, t0);
    k = 0;
    while (!cnt_en && k < 20) begin @(negedge clk); k++; end
    vectors++;
    if (cnt_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_reach_mul: cnt_en=%b want 1", cnt_en);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (outs !== 11'd0) begin
      miscompares++;
      $display("FAIL rmid_cleared: outs=%b want 0", outs);
    end
    rst_n = 1'b1;
    go = 1'b0;
    void'(sbq.pop_back());
    start(3, 1, t0);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      if (j >= 6) begin
        vectors++;
        if (done !== (j == 7)) begin
          miscompares++;
          $display("FAIL rmid_n3_t%0d: done=%b want %b", j, done, j == 7);
        end
      end
    end
    go = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; n_in = '0;
    test_reset();
    test_n5();
    test_small(0);
    test_small(1);
    test_err();
    test_go_toggle();
    test_reset_mid();
    repeat (2) @(negedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d pending want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
